// File: rtl/reg_write_sequencer_pkg.sv
// Shared register-map constants, request payload and sequencer state type.
// ALL_LED expansion items are present only when REG_WRITE_SEQ_ALL_LED_EN is defined.
package pca_registers;

  localparam int unsigned ID_W         = 8;
  localparam int unsigned VAL_W        = 8;
  localparam logic [7:0]  ALL_LED_BASE = 8'hFA;
  localparam logic [7:0]  ALL_LED_LAST = 8'hFD;
  localparam logic [7:0]  LED0_BASE    = 8'h06;
  localparam int unsigned LED_STRIDE   = 4;
  localparam int unsigned LED_CHANNELS = 16;
  localparam int unsigned CH_W         = $clog2(LED_CHANNELS);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [VAL_W-1:0] value;
  } wr_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef REG_WRITE_SEQ_ALL_LED_EN
    ST_EXPAND = 2'd2,
`endif
    ST_ISSUE  = 2'd1
  } seq_state_e;

`ifdef REG_WRITE_SEQ_ALL_LED_EN
  function automatic logic is_all_led(input logic [ID_W-1:0] id);
    return (id >= ALL_LED_BASE) && (id <= ALL_LED_LAST);
  endfunction

  // Register address of LED channel ch for ALL_LED sub-register k.
  function automatic logic [ID_W-1:0] led_id(input logic [1:0] k, input logic [CH_W-1:0] ch);
    return LED0_BASE + ID_W'(LED_STRIDE) * ID_W'(ch) + ID_W'(k);
  endfunction
`endif

endpackage

// File: rtl/reg_write_fifo.sv
// Power-of-two write buffer; a pop in the same cycle frees room for a push when full.
module reg_write_fifo
  import pca_registers::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  wr_req_t                  push_data_i,
  input  logic                     pop_i,
  output wr_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wr_req_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/reg_write_sequencer.sv
// Merges buffered I2C writes and local requester writes onto one register-file write port.
// Define REG_WRITE_SEQ_ALL_LED_EN to expand ALL_LED writes into 16 per-channel writes.
module reg_write_sequencer
  import pca_registers::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_wr_en_i,
  input  logic [ID_W-1:0]  a_wr_id_i,
  input  logic [VAL_W-1:0] a_wr_value_i,
  input  logic             b_valid_i,
  input  logic [ID_W-1:0]  b_id_i,
  input  logic [VAL_W-1:0] b_value_i,
  output logic             b_ready_o,
  input  logic             flush_i,
  output logic             wr_en_o,
  output logic [ID_W-1:0]  wr_id_o,
  output logic [VAL_W-1:0] wr_value_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e       state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [ID_W-1:0]  wr_id_q, wr_id_d;
  logic [VAL_W-1:0] wr_value_q, wr_value_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
`ifdef REG_WRITE_SEQ_ALL_LED_EN
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [1:0]       k_q, k_d;
`endif

  wr_req_t          fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] cnt_d;
  logic             fifo_pop;
  logic             a_push;
  logic             push_drop;
  logic             grant;
  logic             grant_window;
  wr_req_t          grant_req;

  assign a_push    = a_wr_en_i & ~flush_i;
  assign push_drop = a_push & fifo_full & ~fifo_pop;
  assign cnt_d     = flush_i ? '0
                   : fifo_count + CNT_W'(a_push & (~fifo_full | fifo_pop)) - CNT_W'(fifo_pop);

  reg_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (a_push),
    .push_data_i ({a_wr_id_i, a_wr_value_i}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      wr_id_q    <= '0;
      wr_value_q <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef REG_WRITE_SEQ_ALL_LED_EN
      ch_q       <= '0;
      k_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_id_q    <= wr_id_d;
      wr_value_q <= wr_value_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef REG_WRITE_SEQ_ALL_LED_EN
      ch_q       <= ch_d;
      k_q        <= k_d;
`endif
    end
  end

  // Grant window opens in IDLE and in an ISSUE that returns to IDLE, giving one write per cycle.
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_id_d      = wr_id_q;
    wr_value_d   = wr_value_q;
    overflow_d   = overflow_q | push_drop;
    fifo_pop     = 1'b0;
    grant        = 1'b0;
    grant_window = 1'b0;
    grant_req    = '0;
`ifdef REG_WRITE_SEQ_ALL_LED_EN
    ch_d         = ch_q;
    k_d          = k_q;
`endif

    case (state_q)
      ST_IDLE: grant_window = 1'b1;
      ST_ISSUE: begin
`ifdef REG_WRITE_SEQ_ALL_LED_EN
        if (is_all_led(wr_id_q)) begin
          state_d = ST_EXPAND;
          k_d     = 2'(wr_id_q - ALL_LED_BASE);
          ch_d    = '0;
          wr_en_d = 1'b1;
          wr_id_d = led_id(2'(wr_id_q - ALL_LED_BASE), '0);
        end else begin
          state_d      = ST_IDLE;
          grant_window = 1'b1;
        end
`else
        state_d      = ST_IDLE;
        grant_window = 1'b1;
`endif
      end
`ifdef REG_WRITE_SEQ_ALL_LED_EN
      ST_EXPAND: begin
        if (ch_q == CH_W'(LED_CHANNELS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = CH_W'(ch_q + 1'b1);
          wr_en_d = 1'b1;
          wr_id_d = led_id(k_q, CH_W'(ch_q + 1'b1));
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // FIFO head has fixed priority over the local requester.
    if (grant_window && !flush_i) begin
      if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        grant     = 1'b1;
        grant_req = fifo_head;
      end else if (b_valid_i) begin
        grant     = 1'b1;
        grant_req = {b_id_i, b_value_i};
      end
    end

    if (grant) begin
      state_d    = ST_ISSUE;
      wr_en_d    = 1'b1;
      wr_id_d    = grant_req.id;
      wr_value_d = grant_req.value;
    end

    if (flush_i) begin
      state_d    = ST_IDLE;
      wr_en_d    = 1'b0;
      wr_id_d    = wr_id_q;
      wr_value_d = wr_value_q;
      overflow_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE) | (cnt_d != '0);
  end

  assign b_ready_o  = grant_window & fifo_empty & ~flush_i & ~rst_i;
  assign wr_en_o    = wr_en_q;
  assign wr_id_o    = wr_id_q;
  assign wr_value_o = wr_value_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/reg_write_sequencer.md
REG_WRITE_SEQUENCER -- requirements
Module: reg_write_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power-of-two depth of the I2C write buffer (legal 2..16).
REQ-002 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: a_wr_en_i  in  1  I2C-side write strobe, one-cycle pulse, no backpressure.
REQ-005 SHALL have ports: a_wr_id_i  in  8  register address; a_wr_value_i  in  8  data.
REQ-006 SHALL have ports: b_valid_i  in  1  local requester write valid; b_id_i  in  8; b_value_i  in  8.
REQ-007 SHALL have ports: b_ready_o  out  1  local write accepted when b_valid_i & b_ready_o.
REQ-008 SHALL have ports: flush_i  in  1  synchronous abort (soft reset).
REQ-009 SHALL have ports: wr_en_o  out  1; wr_id_o  out  8; wr_value_o  out  8  register-file write port.
REQ-010 SHALL have ports: busy_o  out  1  FIFO non-empty or sequence active; overflow_o  out  1  sticky drop flag.

Function
REQ-011 SHALL push every a_wr_en_i pulse into a FIFO of FIFO_DEPTH entries {id,value}.
REQ-012 SHALL, on push while full with no same-cycle pop, drop the entry and set overflow_o until rst_i or flush_i.
REQ-013 SHALL accept a push to a full FIFO when a pop occurs in the same cycle.
REQ-014 SHALL use states IDLE, ISSUE, EXPAND; IDLE->ISSUE on grant; ISSUE->IDLE or ->EXPAND; EXPAND->IDLE after channel 15.
REQ-015 SHALL grant in IDLE with fixed priority: FIFO head over port B; b_ready_o = IDLE & FIFO empty & !flush_i.
REQ-016 SHALL register the granted request and drive wr_en_o=1 with its id/value exactly one cycle after grant (ISSUE).
REQ-017 SHALL, when the issued id is 0xFA..0xFD (ALL_LED, k=id-0xFA), then emit 16 consecutive writes id=0x06+4n+k, n=0..15, same value, one per cycle.
REQ-018 SHALL not grant any new request during ISSUE or EXPAND; FIFO continues to accept pushes.
REQ-019 SHALL sustain one write per cycle for back-to-back non-ALL_LED requests (grant again in the ISSUE cycle returning to IDLE).
REQ-020 SHALL hold wr_en_o=0, wr_id_o/wr_value_o stable at last values, when no write is issued.
REQ-021 SHALL, on flush_i, clear FIFO, clear overflow_o, abort EXPAND, force IDLE, and suppress wr_en_o from the next cycle; a push coincident with flush_i is discarded.
REQ-022 SHALL treat ids 0xFE/0xFF and all others as single pass-through writes.

Reset
REQ-023 SHALL, on rst_i assertion, immediately clear: state=IDLE, FIFO pointers/count=0, wr_en_o=0, wr_id_o=0, wr_value_o=0, overflow_o=0, busy_o=0, b_ready_o=0 while asserted.
REQ-024 SHALL abort any EXPAND mid-sequence on reset with no further writes after release.

Configuration
REQ-025 SHALL compile ALL_LED expansion only when REG_WRITE_SEQ_ALL_LED_EN is defined; undefined: ALL_LED ids are single pass-through writes, EXPAND state absent.

Structure
REQ-026 SHALL place state enum, ALL_LED base 0xFA, LED0 base 0x06, LED stride 4, channel count 16 in the shared pca_registers package.
REQ-027 SHALL implement the buffer as sub-module reg_write_fifo (push/pop/full/empty/count).

Verification
REQ-028 Single I2C write id=0x06 val=0x55 -> wr_en_o one cycle, id 0x06 val 0x55, two cycles after strobe.
REQ-029 I2C write id=0xFC val=0x10 (EN) -> 17 writes: 0xFC, then 0x08,0x0C,...,0x44 all 0x10, contiguous; without macro -> single 0xFC write.
REQ-030 Five strobes, FIFO_DEPTH=4, during an ALL_LED expansion -> fifth dropped, overflow_o=1, four issued in order.
REQ-031 b_valid_i held with I2C traffic pending -> b_ready_o low until FIFO drains, then B write issued once.
REQ-032 flush_i at expansion channel 5 -> no write after cycle following flush, busy_o=0, overflow_o=0.
REQ-033 rst_i pulsed mid-expansion -> all outputs 0 asynchronously, no writes after release until new strobe.
